dual_addr_ram: RTL and testbench

//   16x8 single-clock RAM with one write/read port (port 0) and one read-only port (port 1).

---
 rtl/dual_addr_ram_pkg.sv | 16 +
 rtl/dual_addr_ram_rdport.sv | 37 +++
 rtl/dual_addr_ram.sv | 82 ++++++++
 tb/tb_dual_addr_ram.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dual_addr_ram_pkg.sv
// Shared widths and word/address types for the dual-address scratch RAM.
package dual_addr_ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

  // Write/read address collision test shared by the top and any wrapper.
  function automatic logic addr_hit(input addr_t a, input addr_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/dual_addr_ram_rdport.sv
// Registered read port: captures the selected word (or the forwarded write data) when enabled.
// Latency 1 cycle; no backpressure, the output simply holds while the port is disabled.
module dual_addr_ram_rdport
  import dual_addr_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_dat,
  input  logic                  byp_vld,
  input  logic [DATA_WIDTH-1:0] byp_dat,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] dout_q;

  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      dout_d = byp_vld ? byp_dat : rd_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/dual_addr_ram.sv
// 16x8 RAM: port 0 writes or reads, port 1 reads only; both outputs registered (1-cycle latency).
// No backpressure. DUAL_ADDR_RAM_BYPASS_EN makes a same-address port-1 read return the word being written.
module dual_addr_ram
  import dual_addr_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_in_0,
  input  logic [ADDR_WIDTH-1:0] addr_in_1,
  input  logic                  port_en_0,
  input  logic                  port_en_1,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic wr_fire;
  logic rd_en_0;
  logic byp_vld_1;

  assign wr_fire = port_en_0 && wr_en;
  // A write cycle on port 0 is not a read: data_out_0 holds.
  assign rd_en_0 = port_en_0 && !wr_en;

`ifdef DUAL_ADDR_RAM_BYPASS_EN
  assign byp_vld_1 = wr_fire && (addr_in_0 == addr_in_1);
`else
  assign byp_vld_1 = 1'b0;
`endif

  always_comb begin
    mem_d = mem_q;
    if (wr_fire) begin
      mem_d[addr_in_0] = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  dual_addr_ram_rdport #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rdport_0 (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (rd_en_0),
    .rd_dat (mem_q[addr_in_0]),
    .byp_vld(1'b0),
    .byp_dat(data_in),
    .dout   (data_out_0)
  );

  // Reads the pre-write array, so without forwarding a collision is read-first.
  dual_addr_ram_rdport #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rdport_1 (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (port_en_1),
    .rd_dat (mem_q[addr_in_1]),
    .byp_vld(byp_vld_1),
    .byp_dat(data_in),
    .dout   (data_out_1)
  );

endmodule

// File: tb/tb_dual_addr_ram.sv
// Directed bench for dual_addr_ram; expected values are hand-computed constants.
module tb_dual_addr_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic [3:0] addr_in_0;
  logic [3:0] addr_in_1;
  logic       port_en_0;
  logic       port_en_1;
  logic [7:0] data_out_0;
  logic [7:0] data_out_1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dual_addr_ram dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .addr_in_0 (addr_in_0),
    .addr_in_1 (addr_in_1),
    .port_en_0 (port_en_0),
    .port_en_1 (port_en_1),
    .data_out_0(data_out_0),
    .data_out_1(data_out_1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; port_en_0 = 0; port_en_1 = 0;
  endtask

  initial begin
    logic [7:0] exp_coll;
    rst = 1; wr_en = 0; data_in = 0; addr_in_0 = 0; addr_in_1 = 0;
    port_en_0 = 0; port_en_1 = 0;
    #3;
    check("reset_out0", data_out_0, 8'h00);
    check("reset_out1", data_out_1, 8'h00);
    cyc();
    rst = 0;
    cyc();

    // Fill: mem[i] = i+1
    for (int i = 0; i < 16; i++) begin
      port_en_0 = 1; wr_en = 1; addr_in_0 = 4'(i); data_in = 8'(i + 1);
      cyc();
    end
    idle();
    port_en_1 = 1;
    for (int i = 0; i < 16; i++) begin
      addr_in_1 = 4'(i);
      cyc();
      check($sformatf("sweep_p1_a%0d", i), data_out_1, 8'(i + 1));
    end

    // Port 0 read-back and hold
    idle();
    port_en_0 = 1; addr_in_0 = 4'd5;
    cyc();
    check("p0_read_a5", data_out_0, 8'h06);
    port_en_0 = 0; addr_in_0 = 4'd2;
    cyc();
    check("p0_hold", data_out_0, 8'h06);

    // Same-address collision
`ifdef DUAL_ADDR_RAM_BYPASS_EN
    exp_coll = 8'hAA;
`else
    exp_coll = 8'h04;
`endif
    port_en_0 = 1; wr_en = 1; addr_in_0 = 4'd3; data_in = 8'hAA;
    port_en_1 = 1; addr_in_1 = 4'd3;
    cyc();
    check("collision_p1", data_out_1, exp_coll);
    check("write_holds_p0", data_out_0, 8'h06);
    idle();
    port_en_1 = 1;
    cyc();
    check("after_collision", data_out_1, 8'hAA);

    // Write to addr 4 while port 1 reads addr 5: independent
    port_en_0 = 1; wr_en = 1; addr_in_0 = 4'd4; data_in = 8'h55;
    port_en_1 = 1; addr_in_1 = 4'd5;
    cyc();
    check("diff_addr_p1", data_out_1, 8'h06);
    idle();
    port_en_1 = 1; addr_in_1 = 4'd4;
    cyc();
    check("diff_addr_wr", data_out_1, 8'h55);

    // wr_en without port_en_0 is ignored
    idle();
    wr_en = 1; addr_in_0 = 4'd7; data_in = 8'hFF;
    cyc();
    idle();
    port_en_1 = 1; addr_in_1 = 4'd7;
    cyc();
    check("no_write_a7", data_out_1, 8'h08);

    // Both ports read the same address
    idle();
    port_en_0 = 1; addr_in_0 = 4'd9;
    port_en_1 = 1; addr_in_1 = 4'd9;
    cyc();
    check("both_a9_p0", data_out_0, 8'h0A);
    check("both_a9_p1", data_out_1, 8'h0A);

    // Disabled port 1 holds
    idle();
    addr_in_1 = 4'd0; addr_in_0 = 4'd0;
    cyc();
    check("p1_hold", data_out_1, 8'h0A);
    check("p0_hold2", data_out_0, 8'h0A);

    // Mid-sequence async reset
    rst = 1;
    #2;
    check("midrst_out0", data_out_0, 8'h00);
    check("midrst_out1", data_out_1, 8'h00);
    cyc();
    rst = 0;
    port_en_0 = 1; port_en_1 = 1;
    for (int k = 0; k < 3; k++) begin
      addr_in_0 = (k == 0) ? 4'd3 : (k == 1) ? 4'd9 : 4'd15;
      addr_in_1 = (k == 0) ? 4'd0 : (k == 1) ? 4'd4 : 4'd12;
      cyc();
      check($sformatf("postrst_p0_%0d", k), data_out_0, 8'h00);
      check($sformatf("postrst_p1_%0d", k), data_out_1, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
